dm_dma: RTL

- Bus-master engine that drives the single-port data memory's `we`/`D`/`addr`/`Q` interface, i.e. the initiator side of that interface.
- Supports two operations:
  - block copy, a memory-to-memory move of `len` words;
  - block fill, writing a constant to `len` words.
- Sits beside the CPU datapath. A port mux outside this block grants memory ownership to `dm_dma` while `busy` is high.

---
 rtl/dm_dma.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dm_dma.sv
// Block copy / block fill master for the single-port data memory; copy costs 2 cycles per word,
// fill 1 cycle per word, plus one DONE cycle. No backpressure: memory is owned while busy is high.
module dm_dma #(
    parameter int DATA_WIDTH       = 16,
    parameter int DM_ADDRESS_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [DM_ADDRESS_WIDTH-1:0] src,
    input  logic [DM_ADDRESS_WIDTH-1:0] dst,
    input  logic [DM_ADDRESS_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0]       fill_value,
    output logic                        busy,
    output logic                        done,
    output logic                        dm_we,
    output logic [DATA_WIDTH-1:0]       dm_D,
    output logic [DM_ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]       dm_Q
);

    localparam int AW = DM_ADDRESS_WIDTH;
    localparam int LW = DM_ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_mode;
    logic [AW-1:0]         r_src;
    logic [AW-1:0]         r_dst;
    logic [LW-1:0]         r_len;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [LW-1:0]         r_i;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [LW-1:0]         w_i_inc;

    assign w_i_inc = r_i + {{AW{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_i     <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_src  <= src;
                        r_dst  <= dst;
                        r_len  <= len;
                        r_fill <= fill_value;
                        r_i    <= '0;
                    end
                end
                S_READ:  r_buf <= dm_Q;
                S_WRITE: r_i   <= w_i_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0)
                        w_next = S_DONE;
                    else if (mode)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:  w_next = S_WRITE;
            S_WRITE: begin
                // i is one bit wider than an address so len = 2^AW can still terminate
                if (w_i_inc == r_len)
                    w_next = S_DONE;
                else if (r_mode)
                    w_next = S_WRITE;
                else
                    w_next = S_READ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Memory-side outputs decode registered state only, so reset drops dm_we without a clock.
    always_comb begin
        dm_we   = 1'b0;
        dm_addr = '0;
        dm_D    = '0;
        case (r_state)
            S_READ: begin
                dm_addr = r_src + r_i[AW-1:0];
            end
            S_WRITE: begin
                dm_we   = 1'b1;
                dm_addr = r_dst + r_i[AW-1:0];
                dm_D    = r_mode ? r_fill : r_buf;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule
